cp_digital_pi: RTL and testbench
================================

CP_DIGITAL_PI -- requirements
Module: cp_digital_pi

Interface
REQ-001 Parameter ACC_W, default 16, integrator and control-word width in bits.
REQ-002 Parameter GAIN_W, default 8, width of the per-direction pump step.
REQ-003 Parameter ACC_INIT, default 2**(ACC_W-1), integrator value loaded at reset.
REQ-004 Parameter RUN_THRESH, default 64, consecutive same-direction pump cycles that raise slip.
REQ-005 Parameter OVL_MAX, default 8, consecutive overlap cycles that raise pfd_stuck.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 en  input  1  update enable; when low, all state holds.
REQ-009 up  input  1  pump-up request from PFD, synchronous to clk.
REQ-010 down  input  1  pump-down request from PFD, synchronous to clk.
REQ-011 gain_up  input  GAIN_W  unsigned integrator step for up.
REQ-012 gain_dn  input  GAIN_W  unsigned integrator step for down.
REQ-013 kp_shift  input  3  proportional-path left shift applied to the active gain.
REQ-014 acc_out  output  ACC_W  unsigned integrator value.
REQ-015 ctrl_out  output  ACC_W  registered integrator plus proportional term, saturated.
REQ-016 sat_hi  output  1  integrator at 2**ACC_W-1.
REQ-017 sat_lo  output  1  integrator at 0.
REQ-018 state_o  output  2  FSM state: 0 IDLE, 1 PUMP_UP, 2 PUMP_DN, 3 OVERLAP.
REQ-019 slip  output  1  run of same-direction pumping reached RUN_THRESH.
REQ-020 pfd_stuck  output  1  sticky overlap fault.

Function
REQ-021 Each rising edge with rst_n=1 and en=1 SHALL set the next state from the current up/down values: 00 IDLE, 10 PUMP_UP, 01 PUMP_DN, 11 OVERLAP; any state SHALL reach any state in one cycle.
REQ-022 Next acc SHALL be min(acc+gain_up, 2**ACC_W-1) on 10, max(acc-gain_dn, 0) on 01, and acc on 00 or 11; the sum SHALL be computed at ACC_W+1 bits before clamping.
REQ-023 acc_out SHALL reflect the update one cycle after up/down are sampled, with latency 1.
REQ-024 ctrl_out SHALL be registered as clamp(acc_next + P, 0, 2**ACC_W-1), with P = +(gain_up<<kp_shift) on 10, -(gain_dn<<kp_shift) on 01, and 0 otherwise; the computation SHALL be signed at ACC_W+GAIN_W+8 bits.
REQ-025 sat_hi and sat_lo SHALL be registered decodes of acc_next.
REQ-026 A run counter SHALL increment, saturating at RUN_THRESH, on each PUMP_UP or PUMP_DN cycle in the same direction as the last pump.
REQ-027 A pump in the opposite direction SHALL load the run counter with 1 and clear slip.
REQ-028 IDLE and OVERLAP cycles SHALL leave the run counter unchanged.
REQ-029 slip SHALL assert on the cycle the counter reaches RUN_THRESH and hold until an opposite-direction pump or reset.
REQ-030 An overlap counter SHALL increment, saturating, on consecutive OVERLAP cycles and clear on any other state.
REQ-031 pfd_stuck SHALL set when the overlap counter reaches OVL_MAX and remain set until reset.
REQ-032 With en=0, acc, ctrl_out, the counters, the flags and the state SHALL hold; up/down SHALL be ignored.
REQ-033 gain_up or gain_dn equal to 0 SHALL still count as a pump for the FSM and run-counter logic.

Reset
REQ-034 On a rising edge with rst_n=0, the block SHALL set acc_out=ACC_INIT, ctrl_out=ACC_INIT, state_o=IDLE, slip=0, pfd_stuck=0, and both counters to 0, with sat_hi and sat_lo decoded from ACC_INIT.
REQ-035 Reset SHALL override en and up/down, and SHALL take effect mid-pump with no partial update.

Verification
REQ-036 Reset release, en=1, up=1 for 3 cycles, gain_up=10, kp_shift=0 -> acc_out 32778, 32788, 32798; ctrl_out 32788, 32798, 32808; state_o=1.
REQ-037 Set acc=65530 via pumping, then up with gain_up=20 -> acc_out=65535, sat_hi=1, ctrl_out=65535; then down with gain_dn=5 -> acc_out=65530, sat_hi=0.
REQ-038 acc=3, down with gain_dn=8, kp_shift=2 -> acc_out=0, sat_lo=1, ctrl_out=0.
REQ-039 up=down=1 for 8 cycles -> acc unchanged, state_o=3, pfd_stuck=1 from the 8th update onward; it stays 1 after the inputs return to 00 until rst_n=0.
REQ-040 64 up cycles interleaved with idle cycles -> slip=1; one down cycle -> slip=0, with the run counter at 1.
REQ-041 en=0 with up=1 for 5 cycles -> all outputs unchanged; rst_n=0 during a pump -> next cycle acc_out=32768, state_o=0.

Source files
------------

// File: rtl/cp_digital_pi.sv
// Digital PI loop filter for a charge-pump PLL: an up/down integrator, a registered
// control word with a proportional kick, and run/overlap supervisors for slip and PFD faults.
module cp_digital_pi #(
    parameter int ACC_W = 16,
    parameter int GAIN_W = 8,
    parameter logic [ACC_W-1:0] ACC_INIT = {1'b1, {(ACC_W-1){1'b0}}},
    parameter int RUN_THRESH = 64,
    parameter int OVL_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              down,
    input  logic [GAIN_W-1:0] gain_up,
    input  logic [GAIN_W-1:0] gain_dn,
    input  logic [2:0]        kp_shift,
    output logic [ACC_W-1:0]  acc_out,
    output logic [ACC_W-1:0]  ctrl_out,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic [1:0]        state_o,
    output logic              slip,
    output logic              pfd_stuck
);

    localparam int CW = ACC_W + GAIN_W + 8;
    localparam int RUN_W = $clog2(RUN_THRESH + 1);
    localparam int OVL_W = $clog2(OVL_MAX + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic signed [CW-1:0] CTRL_MAX = $signed({{(CW-ACC_W){1'b0}}, ACC_MAX});
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(RUN_THRESH);
    localparam logic [OVL_W-1:0] OVL_LIM = OVL_W'(OVL_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUMP_UP = 2'd1,
        PUMP_DN = 2'd2,
        OVERLAP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  ctrl_q, ctrl_d;
    logic              sat_hi_q, sat_hi_d;
    logic              sat_lo_q, sat_lo_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              last_dn_q, last_dn_d;
    logic              slip_q, slip_d;
    logic [OVL_W-1:0]  ovl_q, ovl_d;
    logic              stuck_q, stuck_d;

    logic [ACC_W:0]         acc_sum;
    logic [CW-1:0]          gu_sh, gd_sh;
    logic signed [CW-1:0]   p_term, ctrl_sum;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ctrl_d    = ctrl_q;
        sat_hi_d  = sat_hi_q;
        sat_lo_d  = sat_lo_q;
        run_d     = run_q;
        last_dn_d = last_dn_q;
        slip_d    = slip_q;
        ovl_d     = ovl_q;
        stuck_d   = stuck_q;
        p_term    = '0;
        ctrl_sum  = '0;
        acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(gain_up);
        gu_sh     = CW'(gain_up) << kp_shift;
        gd_sh     = CW'(gain_dn) << kp_shift;

        if (en) begin
            unique case ({up, down})
                2'b10: begin
                    state_d = PUMP_UP;
                    acc_d   = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
                    p_term  = $signed(gu_sh);
                end
                2'b01: begin
                    state_d = PUMP_DN;
                    acc_d   = (acc_q < ACC_W'(gain_dn)) ? '0 : acc_q - ACC_W'(gain_dn);
                    p_term  = -$signed(gd_sh);
                end
                2'b11:   state_d = OVERLAP;
                default: state_d = IDLE;
            endcase

            ctrl_sum = $signed(CW'(acc_d)) + p_term;
            if (ctrl_sum[CW-1])
                ctrl_d = '0;
            else if (ctrl_sum > CTRL_MAX)
                ctrl_d = ACC_MAX;
            else
                ctrl_d = ctrl_sum[ACC_W-1:0];

            sat_hi_d = (acc_d == ACC_MAX);
            sat_lo_d = (acc_d == '0);

            // A pump in the remembered direction extends the run; a reversal restarts it.
            if (up ^ down) begin
                if (down == last_dn_q) begin
                    if (run_q != RUN_LIM)
                        run_d = run_q + RUN_W'(1);
                    if (run_d == RUN_LIM)
                        slip_d = 1'b1;
                end else begin
                    run_d  = RUN_W'(1);
                    slip_d = 1'b0;
                end
                last_dn_d = down;
            end

            if (up & down) begin
                if (ovl_q != OVL_LIM)
                    ovl_d = ovl_q + OVL_W'(1);
                if (ovl_d == OVL_LIM)
                    stuck_d = 1'b1;
            end else begin
                ovl_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= ACC_INIT;
            ctrl_q    <= ACC_INIT;
            sat_hi_q  <= (ACC_INIT == ACC_MAX);
            sat_lo_q  <= (ACC_INIT == '0);
            run_q     <= '0;
            last_dn_q <= 1'b0;
            slip_q    <= 1'b0;
            ovl_q     <= '0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ctrl_q    <= ctrl_d;
            sat_hi_q  <= sat_hi_d;
            sat_lo_q  <= sat_lo_d;
            run_q     <= run_d;
            last_dn_q <= last_dn_d;
            slip_q    <= slip_d;
            ovl_q     <= ovl_d;
            stuck_q   <= stuck_d;
        end
    end

    assign acc_out   = acc_q;
    assign ctrl_out  = ctrl_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign state_o   = state_q;
    assign slip      = slip_q;
    assign pfd_stuck = stuck_q;

endmodule

// File: tb/tb_cp_digital_pi.sv
// Bench for cp_digital_pi: directed scenarios plus a random tail, each cycle's expected
// outputs come from an integer reference model and are checked through a scoreboard queue.
module tb_cp_digital_pi;

    localparam int W = 38;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic [7:0]  gain_up = '0;
    logic [7:0]  gain_dn = '0;
    logic [2:0]  kp_shift = '0;
    logic [15:0] acc_out, ctrl_out;
    logic        sat_hi, sat_lo, slip, pfd_stuck;
    logic [1:0]  state_o;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model state
    int  m_acc, m_ctrl, m_state, m_run, m_ovl;
    bit  m_shi, m_slo, m_slip, m_stuck, m_last_dn;

    cp_digital_pi dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down),
        .gain_up(gain_up), .gain_dn(gain_dn), .kp_shift(kp_shift),
        .acc_out(acc_out), .ctrl_out(ctrl_out), .sat_hi(sat_hi), .sat_lo(sat_lo),
        .state_o(state_o), .slip(slip), .pfd_stuck(pfd_stuck)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_vec();
        return {16'(m_acc), 16'(m_ctrl), m_shi, m_slo, 2'(m_state), m_slip, m_stuck};
    endfunction

    task automatic model_update(input bit r, input bit e, input bit u, input bit d,
                                input int gu, input int gd, input int ks);
        longint p, c;
        int nacc;
        if (!r) begin
            m_acc = 32768; m_ctrl = 32768; m_state = 0; m_run = 0; m_ovl = 0;
            m_shi = 0; m_slo = 0; m_slip = 0; m_stuck = 0; m_last_dn = 0;
        end else if (e) begin
            nacc = m_acc;
            p = 0;
            if (u && !d) begin
                nacc = (m_acc + gu > 65535) ? 65535 : m_acc + gu;
                p = longint'(gu) * (longint'(1) << ks);
                m_state = 1;
            end else if (!u && d) begin
                nacc = (m_acc - gd < 0) ? 0 : m_acc - gd;
                p = -(longint'(gd) * (longint'(1) << ks));
                m_state = 2;
            end else begin
                m_state = (u && d) ? 3 : 0;
            end
            c = longint'(nacc) + p;
            m_ctrl = (c < 0) ? 0 : (c > 65535) ? 65535 : int'(c);
            m_acc = nacc;
            m_shi = (nacc == 65535);
            m_slo = (nacc == 0);
            if (u != d) begin
                if (d == m_last_dn) begin
                    m_run = (m_run >= 64) ? 64 : m_run + 1;
                    if (m_run == 64) m_slip = 1;
                end else begin
                    m_run = 1;
                    m_slip = 0;
                end
                m_last_dn = d;
            end
            if (u && d) begin
                m_ovl = (m_ovl >= 8) ? 8 : m_ovl + 1;
                if (m_ovl == 8) m_stuck = 1;
            end else begin
                m_ovl = 0;
            end
        end
    endtask

    // One clock: drive at the falling edge, predict, then check 1 ns after the rising edge.
    task automatic step(input bit r, input bit e, input bit u, input bit d,
                        input int gu, input int gd, input int ks, input string tag);
        logic [W-1:0] got, exp;
        @(negedge clk);
        rst_n = r; en = e; up = u; down = d;
        gain_up = 8'(gu); gain_dn = 8'(gd); kp_shift = 3'(ks);
        model_update(r, e, u, d, gu, gd, ks);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        got = {acc_out, ctrl_out, sat_hi, sat_lo, state_o, slip, pfd_stuck};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: acc/ctrl/shi/slo/st/slip/stuck got %0d/%0d/%b/%b/%0d/%b/%b exp %0d/%0d/%b/%b/%0d/%b/%b",
                   tag, got[37:22], got[21:6], got[5], got[4], got[3:2], got[1], got[0],
                   exp[37:22], exp[21:6], exp[5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 1, 1, 1, 9, 9, 3, "reset_overrides");

        // first pumps after reset release
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 10, 0, 0, "up_seq");

        // integrator saturation high, then back off
        step(0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 128; i++) step(1, 1, 1, 0, 255, 0, 0, "climb");
        step(1, 1, 1, 0, 122, 0, 0, "climb_last");
        step(1, 1, 1, 0, 20, 0, 0, "sat_hi");
        step(1, 1, 0, 1, 0, 5, 0, "unsat_hi");

        // integrator saturation low with negative proportional clamp
        step(0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 128; i++) step(1, 1, 0, 1, 0, 255, 0, "descend");
        step(1, 1, 0, 1, 0, 125, 0, "descend_last");
        step(1, 1, 0, 1, 0, 8, 2, "sat_lo");

        // overlap fault is sticky until reset
        step(0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 9; i++) step(1, 1, 1, 1, 7, 7, 1, "overlap");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 7, 7, 1, "stuck_hold");
        step(1, 1, 1, 0, 0, 0, 0, "zero_gain_pump");
        step(0, 1, 0, 0, 0, 0, 0, "stuck_clear");

        // same-direction run with idle gaps raises slip, reversal clears it
        for (int i = 0; i < 64; i++) begin
            step(1, 1, 1, 0, 1, 0, 0, "slip_run");
            step(1, 1, 0, 0, 1, 0, 0, "slip_idle");
        end
        step(1, 1, 0, 1, 0, 1, 0, "slip_clear");
        for (int i = 0; i < 63; i++) step(1, 1, 0, 1, 0, 1, 1, "slip_rerun");
        step(1, 1, 1, 1, 3, 3, 0, "slip_overlap_hold");

        // enable gating and reset in the middle of a pump
        step(1, 1, 1, 0, 40, 0, 4, "pump");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 40, 0, 4, "en_hold");
        step(1, 1, 1, 0, 40, 0, 4, "pump");
        step(0, 1, 1, 0, 40, 0, 4, "rst_mid_pump");

        // random mix
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
